// File: rtl/dffx_pipe.sv
// dffx_pipe: a WIDTH-bit, DEPTH-stage register delay line in which every stage
// carries a valid bit. It generalises the single-bit synchronous set/reset
// flops to a tapped delay line.
//   CLK     : clock; all state updates on the rising edge
//   RESET   : synchronous active-high reset. Loads RST_VAL into every data
//             stage and clears the valid bits and OCC. Overrides CE.
//   CE      : enables the shift of data and valid bits and the OCC update
//   D/VLD_I : data and valid bit entering stage 0
//   TAP     : stage selected for Q_TAP/VLD_TAP. Values >= DEPTH read the last stage.
//   Q/VLD_O : data and valid bit of the last stage (registered)
//   Q_TAP/VLD_TAP : data and valid bit of stage TAP (combinational mux)
//   OCC     : number of stages whose valid bit is set (registered)
module dffx_pipe #(
  parameter int unsigned      WIDTH   = 8,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [WIDTH-1:0] INIT    = '0,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter int unsigned      TW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned      OW      = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic [WIDTH-1:0] D,
  input  logic             VLD_I,
  input  logic [TW-1:0]    TAP,
  output logic [WIDTH-1:0] Q,
  output logic             VLD_O,
  output logic [WIDTH-1:0] Q_TAP,
  output logic             VLD_TAP,
  output logic [OW-1:0]    OCC
);

  // Declaration initialisers supply the power-up state (INIT data, no valids).
  logic [DEPTH-1:0][WIDTH-1:0] s_q = {DEPTH{INIT}};
  logic [DEPTH-1:0][WIDTH-1:0] s_d;
  logic [DEPTH-1:0]            v_q = '0;
  logic [DEPTH-1:0]            v_d;
  logic [OW-1:0]               occ_q = '0;
  logic [OW-1:0]               occ_d;

  always_comb begin
    s_d   = s_q;
    v_d   = v_q;
    occ_d = occ_q;
    if (CE) begin
      s_d[0] = D;
      v_d[0] = VLD_I;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        s_d[i] = s_q[i-1];
        v_d[i] = v_q[i-1];
      end
      // An entry arriving and an entry leaving on the same edge cancel out,
      // so OCC moves by at most one and stays within 0..DEPTH.
      if (VLD_I && !v_q[DEPTH-1]) begin
        occ_d = occ_q + OW'(1);
      end else if (!VLD_I && v_q[DEPTH-1]) begin
        occ_d = occ_q - OW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s_q   <= {DEPTH{RST_VAL}};
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      s_q   <= s_d;
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

  // The default is the last stage, so out-of-range TAP values clamp to it.
  always_comb begin
    Q_TAP   = s_q[DEPTH-1];
    VLD_TAP = v_q[DEPTH-1];
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (32'(TAP) == i) begin
        Q_TAP   = s_q[i];
        VLD_TAP = v_q[i];
      end
    end
  end

  assign Q     = s_q[DEPTH-1];
  assign VLD_O = v_q[DEPTH-1];
  assign OCC   = occ_q;

endmodule

// File: tb/tb_dffx_pipe.sv
// Directed testbench for dffx_pipe. Three instances share the clock and the
// data/control inputs:
//   u_d4 : DEPTH=4, INIT=A5, RST_VAL=FF
//   u_d3 : DEPTH=3
//   u_d1 : DEPTH=1
module tb_dffx_pipe;

  logic       clk = 1'b0;
  logic       run_clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b0;
  logic [7:0] d = '0;
  logic       vld_i = 1'b0;

  logic [1:0] tap4 = '0;
  logic [7:0] q4, q_tap4;
  logic       vld_o4, vld_tap4;
  logic [2:0] occ4;

  logic [1:0] tap3 = '0;
  logic [7:0] q3, q_tap3;
  logic       vld_o3, vld_tap3;
  logic [1:0] occ3;

  logic [0:0] tap1 = '0;
  logic [7:0] q1, q_tap1;
  logic       vld_o1, vld_tap1;
  logic [0:0] occ1;

  int tests = 0;
  int fails = 0;

  dffx_pipe #(.WIDTH(8), .DEPTH(4), .INIT(8'hA5), .RST_VAL(8'hFF)) u_d4 (
    .CLK(clk), .RESET(reset), .CE(ce), .D(d), .VLD_I(vld_i), .TAP(tap4),
    .Q(q4), .VLD_O(vld_o4), .Q_TAP(q_tap4), .VLD_TAP(vld_tap4), .OCC(occ4)
  );

  dffx_pipe #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .CLK(clk), .RESET(reset), .CE(ce), .D(d), .VLD_I(vld_i), .TAP(tap3),
    .Q(q3), .VLD_O(vld_o3), .Q_TAP(q_tap3), .VLD_TAP(vld_tap3), .OCC(occ3)
  );

  dffx_pipe #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .CLK(clk), .RESET(reset), .CE(ce), .D(d), .VLD_I(vld_i), .TAP(tap1),
    .Q(q1), .VLD_O(vld_o1), .Q_TAP(q_tap1), .VLD_TAP(vld_tap1), .OCC(occ1)
  );

  always #5 if (run_clk) clk = ~clk;

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ce    = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++; if (q4 !== 8'hA5) begin fails++; $display("FAIL powerup_q got %h exp a5", q4); end
    tests++; if (q_tap4 !== 8'hA5) begin fails++; $display("FAIL powerup_qtap got %h exp a5", q_tap4); end
    tests++; if (vld_o4 !== 1'b0) begin fails++; $display("FAIL powerup_vld got %b exp 0", vld_o4); end
    tests++; if (occ4 !== 3'd0) begin fails++; $display("FAIL powerup_occ got %0d exp 0", occ4); end
    run_clk = 1'b1;
    reset = 1'b1;
    ce    = 1'b1;
    vld_i = 1'b1;
    d     = 8'h33;
    step();
    reset = 1'b0;
    tests++; if (q4 !== 8'hFF) begin fails++; $display("FAIL reset_q got %h exp ff", q4); end
    tests++; if (q_tap4 !== 8'hFF) begin fails++; $display("FAIL reset_qtap got %h exp ff", q_tap4); end
    tests++; if (vld_o4 !== 1'b0 || vld_tap4 !== 1'b0) begin fails++; $display("FAIL reset_vld got %b%b exp 00", vld_o4, vld_tap4); end
    tests++; if (occ4 !== 3'd0) begin fails++; $display("FAIL reset_occ got %0d exp 0", occ4); end
  endtask

  task automatic test_fill();
    logic [2:0] exp_occ [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    logic [7:0] exp_q   [5] = '{8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02};
    logic       exp_vld [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    ce = 1'b1;
    vld_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      d = 8'(k + 1);
      step();
      tests++; if (occ4 !== exp_occ[k]) begin fails++; $display("FAIL fill_occ[%0d] got %0d exp %0d", k, occ4, exp_occ[k]); end
      tests++; if (q4 !== exp_q[k]) begin fails++; $display("FAIL fill_q[%0d] got %h exp %h", k, q4, exp_q[k]); end
      tests++; if (vld_o4 !== exp_vld[k]) begin fails++; $display("FAIL fill_vld[%0d] got %b exp %b", k, vld_o4, exp_vld[k]); end
    end
  endtask

  task automatic test_stall();
    logic       ce_pat  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] d_pat   [6] = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h03, 8'h04};
    logic [2:0] exp_occ [6] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [7:0] exp_q   [6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01};
    logic [7:0] exp_tap [6] = '{8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 8'h03};
    do_reset();
    tap4  = 2'd1;
    vld_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ce = ce_pat[k];
      d  = d_pat[k];
      step();
      tests++; if (occ4 !== exp_occ[k]) begin fails++; $display("FAIL stall_occ[%0d] got %0d exp %0d", k, occ4, exp_occ[k]); end
      tests++; if (q4 !== exp_q[k]) begin fails++; $display("FAIL stall_q[%0d] got %h exp %h", k, q4, exp_q[k]); end
      tests++; if (q_tap4 !== exp_tap[k]) begin fails++; $display("FAIL stall_qtap1[%0d] got %h exp %h", k, q_tap4, exp_tap[k]); end
    end
    tap4 = 2'd0;
  endtask

  task automatic test_alternate();
    logic [2:0] exp_occ [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    logic       exp_vld [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    ce = 1'b1;
    for (int k = 0; k < 8; k++) begin
      vld_i = (k % 2 == 0);
      d = 8'(8'h40 + k);
      step();
      tests++; if (occ4 !== exp_occ[k]) begin fails++; $display("FAIL alt_occ[%0d] got %0d exp %0d", k, occ4, exp_occ[k]); end
      tests++; if (vld_o4 !== exp_vld[k]) begin fails++; $display("FAIL alt_vld[%0d] got %b exp %b", k, vld_o4, exp_vld[k]); end
    end
    // Bubbles carry data too: after 8 edges stage 3 holds the 5th input.
    tests++; if (q4 !== 8'h44) begin fails++; $display("FAIL alt_q got %h exp 44", q4); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ce = 1'b1;
    vld_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d = 8'(8'h10 + k);
      step();
    end
    tests++; if (occ4 !== 3'd4) begin fails++; $display("FAIL full_occ got %0d exp 4", occ4); end
    reset = 1'b1;
    ce    = 1'b0;
    step();
    tests++; if (occ4 !== 3'd0) begin fails++; $display("FAIL rstfull_occ got %0d exp 0", occ4); end
    tests++; if (q4 !== 8'hFF) begin fails++; $display("FAIL rstfull_q got %h exp ff", q4); end
    tests++; if (vld_o4 !== 1'b0 || vld_tap4 !== 1'b0) begin fails++; $display("FAIL rstfull_vld got %b%b exp 00", vld_o4, vld_tap4); end
    reset = 1'b0;
    ce    = 1'b1;
    vld_i = 1'b1;
    d     = 8'h77;
    step();
    tests++; if (occ4 !== 3'd1) begin fails++; $display("FAIL post_rst_occ got %0d exp 1", occ4); end
    tests++; if (vld_tap4 !== 1'b1) begin fails++; $display("FAIL post_rst_vldtap got %b exp 1", vld_tap4); end
    tests++; if (q_tap4 !== 8'h77) begin fails++; $display("FAIL post_rst_qtap got %h exp 77", q_tap4); end
  endtask

  task automatic test_tap_clamp();
    logic [7:0] feed    [3] = '{8'd30, 8'd20, 8'd10};
    logic [7:0] exp_tap [4] = '{8'd10, 8'd20, 8'd30, 8'd30};
    do_reset();
    ce = 1'b1;
    vld_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d = feed[k];
      step();
    end
    ce = 1'b0;
    tests++; if (q3 !== 8'd30) begin fails++; $display("FAIL d3_q got %0d exp 30", q3); end
    tests++; if (occ3 !== 2'd3) begin fails++; $display("FAIL d3_occ got %0d exp 3", occ3); end
    for (int t = 0; t < 4; t++) begin
      tap3 = 2'(t);
      #1;
      tests++; if (q_tap3 !== exp_tap[t]) begin fails++; $display("FAIL d3_qtap[%0d] got %0d exp %0d", t, q_tap3, exp_tap[t]); end
      tests++; if (vld_tap3 !== 1'b1) begin fails++; $display("FAIL d3_vldtap[%0d] got %b exp 1", t, vld_tap3); end
    end
    // The single-stage instance holds the last value fed in.
    for (int t = 0; t < 2; t++) begin
      tap1 = 1'(t);
      #1;
      tests++; if (q_tap1 !== 8'd10 || q1 !== 8'd10) begin fails++; $display("FAIL d1_qtap[%0d] got %0d/%0d exp 10/10", t, q_tap1, q1); end
      tests++; if (vld_tap1 !== 1'b1 || occ1 !== 1'b1) begin fails++; $display("FAIL d1_vld[%0d] got %b/%0d exp 1/1", t, vld_tap1, occ1); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_alternate();
    test_back_to_back();
    test_tap_clamp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
